clock_set_ctrl: RTL and testbench



---
 rtl/clock_set_ctrl.sv | 183 ++++++++++++++++++
 tb/tb_clock_set_ctrl.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/clock_set_ctrl.sv
// 24-hour timekeeping core with a three-key set mode (mode / next / inc).
// Produces registered hours/minutes/seconds and the selected digit for the display.

module clock_set_key #(
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic clk,
   input  logic rst,
   input  logic key,
   output logic press
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DW-1:0] DB_LAST = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1, sync2;
   logic          level, level_prev;
   logic          fill1, fill2, armed;
   logic [DW-1:0] db_cnt;

   // armed stays low until the key has been seen released after reset, so a key
   // held through reset never produces a press.
   always_ff @(posedge clk) begin
      if (rst) begin
         sync1      <= 1'b0;
         sync2      <= 1'b0;
         level      <= 1'b0;
         level_prev <= 1'b0;
         fill1      <= 1'b0;
         fill2      <= 1'b0;
         armed      <= 1'b0;
         db_cnt     <= '0;
         press      <= 1'b0;
      end else begin
         sync1      <= key;
         sync2      <= sync1;
         fill1      <= 1'b1;
         fill2      <= fill1;
         level_prev <= level;
         if (sync2 == level) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_LAST) begin
            level  <= sync2;
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + 1'b1;
         end
         if (fill2 && !sync2 && !level)
            armed <= 1'b1;
         press <= level & ~level_prev & armed;
      end
   end
endmodule

// state | meaning
// RUN   | time advances on each tick, pos = 7, setting = 0
// SET   | time frozen, inc edits digit at pos, next moves pos, setting = 1
module clock_set_ctrl #(
   parameter int CLK_FREQ        = 50000000,
   parameter int DEBOUNCE_CYCLES = 1000000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       key_mode,
   input  logic       key_next,
   input  logic       key_inc,
   output logic [5:0] hours,
   output logic [5:0] minutes,
   output logic [5:0] seconds,
   output logic [2:0] pos,
   output logic       setting
);
   localparam int TW = $clog2(CLK_FREQ + 1);
   localparam logic [TW-1:0] TICK_LAST = TW'(CLK_FREQ - 1);

   typedef enum logic {RUN, SET} state_t;

   state_t        state;
   logic [TW-1:0] tick_cnt;
   logic          tick;
   logic          mode_p, next_p, inc_p;
   logic [5:0]    edit_hr, edit_min, edit_sec;

   clock_set_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_mode (
      .clk(clk), .rst(rst), .key(key_mode), .press(mode_p));
   clock_set_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_next (
      .clk(clk), .rst(rst), .key(key_next), .press(next_p));
   clock_set_key #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_key_inc (
      .clk(clk), .rst(rst), .key(key_inc), .press(inc_p));

   function automatic logic [5:0] inc_units(input logic [5:0] v, input logic [5:0] top);
      logic [5:0] t, u;
      t = v / 6'd10;
      u = v % 6'd10;
      u = (u == top) ? 6'd0 : u + 6'd1;
      return t * 6'd10 + u;
   endfunction

   function automatic logic [5:0] inc_tens(input logic [5:0] v, input logic [5:0] top);
      logic [5:0] t, u;
      t = v / 6'd10;
      u = v % 6'd10;
      t = (t == top) ? 6'd0 : t + 6'd1;
      return t * 6'd10 + u;
   endfunction

   // Stepping hour tens to 2 clamps units to 3 so the hour stays within 0..23.
   function automatic logic [5:0] inc_hr_tens(input logic [5:0] v);
      logic [5:0] t, u;
      t = v / 6'd10;
      u = v % 6'd10;
      t = (t == 6'd2) ? 6'd0 : t + 6'd1;
      if (t == 6'd2 && u > 6'd3)
         u = 6'd3;
      return t * 6'd10 + u;
   endfunction

   assign tick = (state == RUN) && (tick_cnt == TICK_LAST);

   always_comb begin
      edit_hr  = hours;
      edit_min = minutes;
      edit_sec = seconds;
      case (pos)
         3'd0: edit_sec = inc_units(seconds, 6'd9);
         3'd1: edit_sec = inc_tens(seconds, 6'd5);
         3'd2: edit_min = inc_units(minutes, 6'd9);
         3'd3: edit_min = inc_tens(minutes, 6'd5);
         3'd4: edit_hr  = inc_units(hours, (hours / 6'd10 == 6'd2) ? 6'd3 : 6'd9);
         3'd5: edit_hr  = inc_hr_tens(hours);
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= RUN;
         hours    <= 6'd0;
         minutes  <= 6'd0;
         seconds  <= 6'd0;
         pos      <= 3'd7;
         setting  <= 1'b0;
         tick_cnt <= '0;
      end else begin
         case (state)
            RUN: begin
               tick_cnt <= tick ? '0 : tick_cnt + 1'b1;
               if (mode_p) begin
                  state    <= SET;
                  pos      <= 3'd0;
                  setting  <= 1'b1;
                  tick_cnt <= '0;
               end else if (tick) begin
                  if (seconds == 6'd59) begin
                     seconds <= 6'd0;
                     if (minutes == 6'd59) begin
                        minutes <= 6'd0;
                        hours   <= (hours == 6'd23) ? 6'd0 : hours + 6'd1;
                     end else begin
                        minutes <= minutes + 6'd1;
                     end
                  end else begin
                     seconds <= seconds + 6'd1;
                  end
               end
            end
            SET: begin
               tick_cnt <= '0;
               if (mode_p) begin
                  state   <= RUN;
                  pos     <= 3'd7;
                  setting <= 1'b0;
               end else if (next_p) begin
                  pos <= (pos == 3'd5) ? 3'd0 : pos + 3'd1;
               end else if (inc_p) begin
                  hours   <= edit_hr;
                  minutes <= edit_min;
                  seconds <= edit_sec;
               end
            end
         endcase
      end
   end
endmodule

// File: tb/tb_clock_set_ctrl.sv
// Self-checking bench for clock_set_ctrl with CLK_FREQ=10, DEBOUNCE_CYCLES=4.
// Expected snapshots are queued when stimulus is driven and popped at sample time.

module tb_clock_set_ctrl;
   localparam int CF = 10;
   localparam int DB = 4;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       key_mode = 1'b0;
   logic       key_next = 1'b0;
   logic       key_inc = 1'b0;
   logic [5:0] hours, minutes, seconds;
   logic [2:0] pos;
   logic       setting;

   clock_set_ctrl #(.CLK_FREQ(CF), .DEBOUNCE_CYCLES(DB)) dut (
      .clk(clk), .rst(rst), .key_mode(key_mode), .key_next(key_next), .key_inc(key_inc),
      .hours(hours), .minutes(minutes), .seconds(seconds), .pos(pos), .setting(setting));

   always #5 clk = ~clk;

   typedef struct {
      string       name;
      logic [21:0] val;
   } exp_t;

   exp_t        exp_q[$];
   exp_t        e;
   int          checks = 0;
   int          errors = 0;
   logic [21:0] obs;

   assign obs = {hours, minutes, seconds, pos, setting};

   function automatic logic [21:0] tv(input int h, input int m, input int s, input int p, input int st);
      return {6'(h), 6'(m), 6'(s), 3'(p), 1'(st)};
   endfunction

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic set_key(input int k, input logic v);
      case (k)
         0: key_mode = v;
         1: key_next = v;
         default: key_inc = v;
      endcase
   endtask

   task automatic press(input int k);
      set_key(k, 1'b1);
      cyc(10);
      set_key(k, 1'b0);
      cyc(10);
   endtask

   task automatic press_n(input int k, input int n);
      for (int i = 0; i < n; i++) press(k);
   endtask

   task automatic do_reset;
      @(negedge clk);
      rst = 1'b1;
      cyc(2);
      rst = 1'b0;
   endtask

   // Reset, then mode pressed after edge 4: SET at edge 12, one tick already at edge 10.
   task automatic go_set;
      do_reset;
      cyc(4);
      key_mode = 1'b1;
      exp_q.push_back('{"go_set_lat7", tv(0, 0, 1, 7, 0)});
      exp_q.push_back('{"go_set_lat8", tv(0, 0, 1, 0, 1)});
      cyc(7);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(3);
      key_mode = 1'b0;
      cyc(10);
   endtask

   task automatic test_reset;
      key_mode = 1'b0; key_next = 1'b0; key_inc = 1'b0;
      do_reset;
      exp_q.push_back('{"reset", tv(0, 0, 0, 7, 0)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
   endtask

   task automatic test_run;
      do_reset;
      for (int i = 1; i <= 5; i++) begin
         exp_q.push_back('{"run_before_tick", tv(0, 0, i - 1, 7, 0)});
         exp_q.push_back('{"run_on_tick", tv(0, 0, i, 7, 0)});
         cyc(9);
         e = exp_q.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s %0d got %h expected %h", e.name, i, obs, e.val); end
         cyc(1);
         e = exp_q.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s %0d got %h expected %h", e.name, i, obs, e.val); end
      end
      exp_q.push_back('{"run_600", tv(0, 1, 0, 7, 0)});
      cyc(550);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
   endtask

   // Mode pulse lands on edge 20, the second tick: the tick must be discarded.
   task automatic test_mode_on_tick;
      do_reset;
      cyc(12);
      key_mode = 1'b1;
      exp_q.push_back('{"tick_mode_before", tv(0, 0, 1, 7, 0)});
      exp_q.push_back('{"tick_mode_set", tv(0, 0, 1, 0, 1)});
      exp_q.push_back('{"set_frozen", tv(0, 0, 1, 0, 1)});
      cyc(7);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(3);
      key_mode = 1'b0;
      cyc(40);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
   endtask

   task automatic test_next_seq;
      for (int i = 1; i <= 6; i++) begin
         press(1);
         exp_q.push_back('{"next_seq", tv(0, 0, 1, i % 6, 1)});
         e = exp_q.pop_front(); checks++;
         if (obs !== e.val) begin errors++; $display("FAIL %s step %0d got %h expected %h", e.name, i, obs, e.val); end
      end
   endtask

   task automatic test_preload_wrap;
      press_n(2, 8); press(1);
      press_n(2, 5); press(1);
      press_n(2, 9); press(1);
      press_n(2, 5); press(1);
      press_n(2, 3); press(1);
      press_n(2, 2);
      exp_q.push_back('{"preload", tv(23, 59, 59, 5, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      key_mode = 1'b1;
      exp_q.push_back('{"wrap_set_to_run", tv(23, 59, 59, 7, 0)});
      exp_q.push_back('{"wrap_cycle9", tv(23, 59, 59, 7, 0)});
      exp_q.push_back('{"wrap_cycle10", tv(0, 0, 0, 7, 0)});
      cyc(8);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(9);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      key_mode = 1'b0;
      cyc(10);
   endtask

   task automatic test_digit_edits;
      go_set;
      press_n(2, 9); press(1);
      press_n(2, 3); press(1);
      press_n(2, 5); press(1);
      press_n(2, 4); press(1);
      press_n(2, 9); press(1);
      press_n(2, 1);
      exp_q.push_back('{"edit_19_45_30", tv(19, 45, 30, 5, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press(2);
      exp_q.push_back('{"hr_tens_clamp", tv(23, 45, 30, 5, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press(2);
      exp_q.push_back('{"hr_tens_wrap", tv(3, 45, 30, 5, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press_n(2, 2);
      press_n(1, 5);
      press(2);
      exp_q.push_back('{"hr_units_wrap_3", tv(20, 45, 30, 4, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press_n(1, 2);
      press_n(2, 9); press(1);
      press_n(2, 2);
      press_n(1, 5);
      exp_q.push_back('{"sec_59_pos0", tv(20, 45, 59, 0, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press(2);
      exp_q.push_back('{"sec_units_wrap", tv(20, 45, 50, 0, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press_n(1, 2);
      press_n(2, 7); press(1);
      press(2);
      exp_q.push_back('{"min_52_pos3", tv(20, 52, 50, 3, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      press(2);
      exp_q.push_back('{"min_tens_wrap", tv(20, 2, 50, 3, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
   endtask

   task automatic test_glitch_latency;
      for (int i = 0; i < 4; i++) begin
         key_inc = 1'b1;
         cyc(3);
         key_inc = 1'b0;
         cyc(3);
      end
      cyc(10);
      exp_q.push_back('{"glitch_ignored", tv(20, 2, 50, 3, 1)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      key_inc = 1'b1;
      exp_q.push_back('{"inc_latency7", tv(20, 2, 50, 3, 1)});
      exp_q.push_back('{"inc_latency8", tv(20, 12, 50, 3, 1)});
      exp_q.push_back('{"hold_single_pulse", tv(20, 12, 50, 3, 1)});
      cyc(DB + 3);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(30);
      key_inc = 1'b0;
      cyc(10);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
   endtask

   task automatic test_mode_inc_same;
      key_mode = 1'b1;
      key_inc  = 1'b1;
      exp_q.push_back('{"mode_inc_before", tv(20, 12, 50, 3, 1)});
      exp_q.push_back('{"mode_beats_inc", tv(20, 12, 50, 7, 0)});
      cyc(7);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      cyc(1);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      key_mode = 1'b0;
      key_inc  = 1'b0;
      cyc(10);
   endtask

   // Mode held through reset: no SET until released and pressed again.
   task automatic test_reset_held;
      key_mode = 1'b1;
      do_reset;
      cyc(20);
      exp_q.push_back('{"held_through_reset", tv(0, 0, 2, 7, 0)});
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      key_mode = 1'b0;
      cyc(10);
      key_mode = 1'b1;
      exp_q.push_back('{"repress_after_reset", tv(0, 0, 3, 0, 1)});
      cyc(8);
      e = exp_q.pop_front(); checks++;
      if (obs !== e.val) begin errors++; $display("FAIL %s got %h expected %h", e.name, obs, e.val); end
      key_mode = 1'b0;
      cyc(10);
   endtask

   initial begin
      test_reset;
      test_run;
      test_mode_on_tick;
      test_next_seq;
      test_preload_wrap;
      test_digit_edits;
      test_glitch_latency;
      test_mode_inc_same;
      test_reset_held;
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
